// File: rtl/rom_bus_arbiter.sv
// Arbitrates the single ROM/PSRAM port between SNES, Cx4 and MCU requesters and
// sequences each access with fixed strobe timing. ACCESS_CYCLES must be >= 3.
module rom_bus_arbiter #(
  parameter int ACCESS_CYCLES = 6,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SNES_REQ,
  input  logic [23:0] SNES_ADDR_IN,
  input  logic        SNES_WE,
  input  logic [7:0]  SNES_WDATA,
  input  logic        CX4_REQ,
  input  logic [23:0] CX4_ADDR,
  input  logic        MCU_REQ,
  input  logic        MCU_WE,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_WDATA,
  input  logic [7:0]  ROM_DI,
  output logic [23:0] ROM_ADDR,
  output logic [7:0]  ROM_DO,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        SNES_VALID,
  output logic [7:0]  SNES_RDATA,
  output logic        CX4_ACK,
  output logic [7:0]  CX4_RDATA,
  output logic        MCU_ACK,
  output logic [7:0]  MCU_RDATA,
  output logic        SNES_OVR,
  output logic        BUSY
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_SNES, SRC_CX4, SRC_MCU} src_t;

  state_t           state, state_n;
  src_t             src_q, win, grant;
  logic [CNT_W-1:0] cnt;
  logic             gnt_we_q;

  logic             snes_pend;
  logic [23:0]      snes_addr_q;
  logic             snes_we_q;
  logic [7:0]       snes_wdata_q;
  logic [STV_W-1:0] starve_cnt;

  logic             arb_en;
  logic             snes_any;
  logic [23:0]      g_addr;
  logic [7:0]       g_wdata;
  logic             g_we;

  assign snes_any = snes_pend | SNES_REQ;
  assign arb_en   = (state == IDLE) || (state == DONE);
  assign BUSY     = (state != IDLE);

  // In DONE the requester just acked still shows its old REQ level; if it would
  // win, nothing is granted this cycle and it competes again from IDLE.
  always_comb begin
    win = SRC_NONE;
    if (snes_any)                                win = SRC_SNES;
    else if (MCU_REQ && starve_cnt == STV_MAX)   win = SRC_MCU;
    else if (CX4_REQ)                            win = SRC_CX4;
    else if (MCU_REQ)                            win = SRC_MCU;

    grant = SRC_NONE;
    if (arb_en && !(state == DONE && win == src_q && win != SRC_SNES))
      grant = win;
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_we    = 1'b0;
    unique case (grant)
      SRC_SNES: begin
        g_addr  = snes_pend ? snes_addr_q  : SNES_ADDR_IN;
        g_wdata = snes_pend ? snes_wdata_q : SNES_WDATA;
        g_we    = snes_pend ? snes_we_q    : SNES_WE;
      end
      SRC_CX4: begin
        g_addr = CX4_ADDR;
      end
      SRC_MCU: begin
        g_addr  = MCU_ADDR;
        g_wdata = MCU_WDATA;
        g_we    = MCU_WE;
      end
      default: ;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (grant != SRC_NONE) state_n = ACCESS;
      ACCESS:  if (cnt == '0)         state_n = DONE;
      DONE:    state_n = (grant != SRC_NONE) ? ACCESS : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ROM_ADDR     <= '0;
      ROM_DO       <= '0;
      ROM_OE_N     <= 1'b1;
      ROM_WE_N     <= 1'b1;
      SNES_VALID   <= 1'b0;
      CX4_ACK      <= 1'b0;
      MCU_ACK      <= 1'b0;
      SNES_RDATA   <= '0;
      CX4_RDATA    <= '0;
      MCU_RDATA    <= '0;
      SNES_OVR     <= 1'b0;
      snes_pend    <= 1'b0;
      snes_addr_q  <= '0;
      snes_we_q    <= 1'b0;
      snes_wdata_q <= '0;
      starve_cnt   <= '0;
      cnt          <= '0;
      src_q        <= SRC_NONE;
      gnt_we_q     <= 1'b0;
    end else begin
      SNES_VALID <= 1'b0;
      CX4_ACK    <= 1'b0;
      MCU_ACK    <= 1'b0;

      if (SNES_REQ) begin
        if (snes_pend) begin
          SNES_OVR <= 1'b1;
        end else begin
          snes_pend    <= 1'b1;
          snes_addr_q  <= SNES_ADDR_IN;
          snes_we_q    <= SNES_WE;
          snes_wdata_q <= SNES_WDATA;
        end
      end

      if (!MCU_REQ || grant == SRC_MCU)
        starve_cnt <= '0;
      else if (grant == SRC_CX4 && starve_cnt != STV_MAX)
        starve_cnt <= starve_cnt + STV_ONE;

      if (grant != SRC_NONE) begin
        src_q    <= grant;
        gnt_we_q <= g_we;
        cnt      <= CNT_LAST;
        ROM_ADDR <= g_addr;
        ROM_DO   <= g_wdata;
        ROM_OE_N <= g_we;
        ROM_WE_N <= 1'b1;
      end else if (state == ACCESS) begin
        if (cnt == '0) begin
          ROM_OE_N <= 1'b1;
          ROM_WE_N <= 1'b1;
          unique case (src_q)
            SRC_SNES: begin
              SNES_RDATA <= ROM_DI;
              SNES_VALID <= 1'b1;
              snes_pend  <= 1'b0;
            end
            SRC_CX4: begin
              CX4_RDATA <= ROM_DI;
              CX4_ACK   <= 1'b1;
            end
            SRC_MCU: begin
              MCU_RDATA <= ROM_DI;
              MCU_ACK   <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          cnt <= cnt - CNT_ONE;
          // WE_N stays high in the first and last ACCESS cycle for address setup/hold.
          ROM_WE_N <= !(gnt_we_q && cnt >= CNT_TWO);
        end
      end
    end
  end

endmodule
